// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the coordinate type used by the renderers.
// The sync-alignment depth applies only when VGA_SYNC_ALIGN_EN is defined.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Renderer latency: one synchronous ROM read plus one colour output register.
  localparam int SYNC_ALIGN_DEPTH = 2;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// vga_delay_line: a DEPTH-stage shift register whose stages all reset to RST_VAL.
// It is used to delay hs/vs so they stay aligned with the renderer pipeline.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel timing generator: DrawX/DrawY, blank, hs/vs, strobes, frame count.
// Define VGA_SYNC_ALIGN_EN to delay hs/vs by SYNC_ALIGN_DEPTH clocks to match the renderers.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  output coord_t                 DrawX,
  output coord_t                 DrawY,
  output logic                   blank,
  output logic                   hs,
  output logic                   vs,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
  end

  coord_t                 hc, vc, hc_n, vc_n;
  logic [FRAME_CNT_W-1:0] fc_n;
  logic                   h_wrap, v_wrap;
  logic                   hs_r, vs_r, hs_n, vs_n, blank_n, ls_n, fs_n;

  // All registered outputs are decoded from the next-state counters so they
  // describe the same (hc,vc) that DrawX/DrawY show in the following cycle.
  always_comb begin
    h_wrap  = (hc == H_LAST);
    v_wrap  = (vc == V_LAST);
    hc_n    = h_wrap ? '0 : hc + 1'b1;
    vc_n    = vc;
    fc_n    = frame_cnt;
    if (h_wrap) begin
      vc_n = v_wrap ? '0 : vc + 1'b1;
      if (v_wrap) fc_n = frame_cnt + 1'b1;
    end
    hs_n    = !((hc_n >= HS_START) && (hc_n < HS_END));
    vs_n    = !((vc_n >= VS_START) && (vc_n < VS_END));
    blank_n = (hc_n < H_ACT) && (vc_n < V_ACT);
    ls_n    = (hc_n == '0);
    fs_n    = (hc_n == '0) && (vc_n == '0);
  end

  // No handshake: the block free-runs and consumers sample every cycle.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc          <= '0;
      vc          <= '0;
      frame_cnt   <= '0;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc          <= hc_n;
      vc          <= vc_n;
      frame_cnt   <= fc_n;
      hs_r        <= hs_n;
      vs_r        <= vs_n;
      blank       <= blank_n;
      line_start  <= ls_n;
      frame_start <= fs_n;
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

`ifdef VGA_SYNC_ALIGN_EN
  logic [1:0] sync_dly;

  vga_delay_line #(
    .WIDTH  (2),
    .DEPTH  (SYNC_ALIGN_DEPTH),
    .RST_VAL(2'b11)
  ) u_sync_dly (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .d      ({hs_r, vs_r}),
    .q      (sync_dly)
  );

  assign hs = sync_dly[1];
  assign vs = sync_dly[0];
`else
  assign hs = hs_r;
  assign vs = vs_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for reset and line timing, and a reduced
// timing instance (32x20 totals, 4-bit frame count) for frame, wrap and mid-frame reset.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  logic vga_clk;
  logic reset_n;

  logic [9:0] def_x, def_y;
  logic       def_blank, def_hs, def_vs, def_ls, def_fs;
  logic [7:0] def_fc;

  logic [9:0] sml_x, sml_y;
  logic       sml_blank, sml_hs, sml_vs, sml_ls, sml_fs;
  logic [3:0] sml_fc;

  int n_vec  = 0;
  int n_fail = 0;

  vga_timing_gen u_def (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (def_x),
    .DrawY      (def_y),
    .blank      (def_blank),
    .hs         (def_hs),
    .vs         (def_vs),
    .line_start (def_ls),
    .frame_start(def_fs),
    .frame_cnt  (def_fc)
  );

  // hs low at x 20..27, vs low on lines 14..15, 640 clocks per frame.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .FRAME_CNT_W(4)
  ) u_sml (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (sml_x),
    .DrawY      (sml_y),
    .blank      (sml_blank),
    .hs         (sml_hs),
    .vs         (sml_vs),
    .line_start (sml_ls),
    .frame_start(sml_fs),
    .frame_cnt  (sml_fc)
  );

  // Clock / reset
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Driver tasks: advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n, blank_err, blank_hi, hs_lo, hs_first, hs_last, ls_cnt, fs_cnt, vs_lo;
    int vs_first, vs_last;
    logic b639, b640, saw_wrap;
    logic [3:0] fc_prev;

    // Reset hold
    reset_n = 1'b0;
    repeat (5) tick();
    chk("rst_def_x", def_x, 0);
    chk("rst_def_y", def_y, 0);
    chk("rst_def_hs", def_hs, 1);
    chk("rst_def_vs", def_vs, 1);
    chk("rst_def_blank", def_blank, 0);
    chk("rst_def_fc", def_fc, 0);
    chk("rst_def_ls", def_ls, 0);
    chk("rst_def_fs", def_fs, 0);
    chk("rst_sml_x", sml_x, 0);
    chk("rst_sml_vs", sml_vs, 1);
    chk("rst_sml_fc", sml_fc, 0);

    // Release: first edge moves hc to 1 and blank rises for visible (1,0)
    reset_n = 1'b1;
    tick();
    chk("rel_def_x", def_x, 1);
    chk("rel_def_y", def_y, 0);
    chk("rel_def_blank", def_blank, 1);
    chk("rel_def_fs", def_fs, 0);
    chk("rel_sml_x", sml_x, 1);

    // Default timing: one full line starting at x=0 of line 1
    n = 0;
    while (def_x !== 10'd0 && n < 1000) begin tick(); n++; end
    chk("def_line_sync_x", def_x, 0);
    chk("def_line_sync_y", def_y, 1);
    blank_err = 0; blank_hi = 0; hs_lo = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    b639 = 1'bx; b640 = 1'bx;
    for (int i = 0; i < 800; i++) begin
      if (def_blank !== (def_x < 10'd640)) blank_err++;
      if (def_blank === 1'b1) blank_hi++;
      if (def_hs === 1'b0) begin
        hs_lo++;
        if (hs_first < 0) hs_first = int'(def_x);
        hs_last = int'(def_x);
      end
      if (def_ls === 1'b1) ls_cnt++;
      if (i == 639) b639 = def_blank;
      if (i == 640) b640 = def_blank;
      if (i == 799) chk("def_x_last", def_x, 799);
      tick();
    end
    chk("def_blank_shape", blank_err, 0);
    chk("def_blank_count", blank_hi, 640);
    chk("def_blank_639", b639, 1);
    chk("def_blank_640", b640, 0);
    chk("def_hs_low_count", hs_lo, 96);
    chk("def_hs_first", hs_first, 656 + LAG);
    chk("def_hs_last", hs_last, 751 + LAG);
    chk("def_line_start_count", ls_cnt, 1);
    chk("def_wrap_x", def_x, 0);
    chk("def_wrap_y", def_y, 2);

    // Reduced timing: full frame from frame_start
    n = 0;
    while (sml_fs !== 1'b1 && n < 1000) begin tick(); n++; end
    chk("sml_fs_found", sml_fs, 1);
    chk("sml_fs_x", sml_x, 0);
    chk("sml_fs_y", sml_y, 0);
    fc_prev = sml_fc;
    blank_err = 0; blank_hi = 0; hs_lo = 0; ls_cnt = 0; fs_cnt = 0; vs_lo = 0;
    vs_first = -1; vs_last = -1;
    for (int i = 0; i < 640; i++) begin
      if (sml_blank !== ((sml_x < 10'd16) && (sml_y < 10'd12))) blank_err++;
      if (sml_blank === 1'b1) blank_hi++;
      if (sml_hs === 1'b0) hs_lo++;
      if (sml_vs === 1'b0) begin
        vs_lo++;
        if (vs_first < 0) vs_first = i;
        vs_last = i;
      end
      if (sml_ls === 1'b1) ls_cnt++;
      if (sml_fs === 1'b1) fs_cnt++;
      tick();
    end
    chk("sml_blank_shape", blank_err, 0);
    chk("sml_blank_count", blank_hi, 192);
    chk("sml_hs_low_count", hs_lo, 160);
    chk("sml_vs_low_count", vs_lo, 64);
    chk("sml_vs_first", vs_first, 448 + LAG);
    chk("sml_vs_last", vs_last, 511 + LAG);
    chk("sml_line_start_count", ls_cnt, 20);
    chk("sml_frame_start_count", fs_cnt, 1);
    chk("sml_frame_wrap_x", sml_x, 0);
    chk("sml_frame_wrap_y", sml_y, 0);
    chk("sml_frame_wrap_fs", sml_fs, 1);
    chk("sml_frame_wrap_fc", sml_fc, 4'(fc_prev + 4'd1));

    // Frame period and frame_cnt wrap over 17 frames
    fc_prev = sml_fc;
    saw_wrap = 1'b0;
    for (int f = 0; f < 17; f++) begin
      n = 0;
      do begin tick(); n++; end while (sml_fs !== 1'b1 && n < 700);
      chk("sml_frame_period", n, 640);
      chk("sml_fc_step", sml_fc, 4'(fc_prev + 4'd1));
      if (fc_prev == 4'd15 && sml_fc == 4'd0) saw_wrap = 1'b1;
      fc_prev = sml_fc;
    end
    chk("sml_fc_wrapped", saw_wrap, 1);

    // Mid-frame reset while hs and vs are both low
    n = 0;
    while (!(sml_x == 10'd24 && sml_y == 10'd15) && n < 700) begin tick(); n++; end
    chk("mid_pos_x", sml_x, 24);
    chk("mid_pre_hs", sml_hs, 0);
    chk("mid_pre_vs", sml_vs, 0);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_hs", sml_hs, 1);
    chk("mid_rst_vs", sml_vs, 1);
    chk("mid_rst_x", sml_x, 0);
    chk("mid_rst_y", sml_y, 0);
    chk("mid_rst_fc", sml_fc, 0);
    chk("mid_rst_blank", sml_blank, 0);
    reset_n = 1'b1;
    tick();
    chk("mid_rel_x", sml_x, 1);
    n = 0;
    while (sml_fs !== 1'b1 && n < 700) begin tick(); n++; end
    chk("mid_first_fs_delay", n, 639);
    chk("mid_first_fs_fc", sml_fc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing generator sitting directly upstream of the sprite/background renderers; it produces DrawX, DrawY and blank, which those renderers consume, plus the physical hs/vs to the VGA connector.
- Default timing is 640x480 at 60 Hz: 800 clocks per line, 525 lines per frame, running on the 25 MHz pixel clock.
- Also emits line/frame strobes and a wrapping frame counter, used by game logic for once-per-frame updates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- FRAME_CNT_W, 8, width of frame_cnt

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- DrawX  out  10  current pixel column (horizontal counter)
- DrawY  out  10  current line (vertical counter)
- blank  out  1  1 = visible region (display enable), 0 = porch/sync
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- line_start  out  1  one-cycle pulse while DrawX==0
- frame_start  out  1  one-cycle pulse while DrawX==0 and DrawY==0
- frame_cnt  out  FRAME_CNT_W  frames completed, wraps modulo 2^FRAME_CNT_W

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- hc and vc are registers; DrawX=hc and DrawY=vc, driven straight from the registers.
- Every clock, hc increments. When hc==H_TOTAL-1, hc wraps to 0 and vc increments.
- When vc==V_TOTAL-1 and hc==H_TOTAL-1, vc wraps to 0 and frame_cnt increments (modulo wrap, no saturation).
- hs, vs, blank, line_start and frame_start are registered. Each is computed from the next-state counter values, so all of them describe the same (hc,vc) that DrawX/DrawY show in that cycle, with zero relative skew.
- hs = 0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs = 0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (lines 490..491), for the whole of each such line.
- blank = 1 iff hc < H_ACTIVE and vc < V_ACTIVE.
- Reset values, valid on the first edge with reset_n=0: hc=0, vc=0, frame_cnt=0, hs=1, vs=1, blank=0, line_start=0, frame_start=0.
- Reset release: the first edge with reset_n=1 advances hc to 1. The first frame_start pulse therefore occurs at the next frame wrap, not at release. blank rises at the first edge where next-state (hc,vc) is visible.
- Reset asserted mid-frame: all state returns to reset values on the next edge, with no partial sync pulse extension. Asserting reset while vs=0 forces vs=1 immediately.
- Widths: 10-bit counters suffice for the defaults. Parameter sets whose H_TOTAL or V_TOTAL exceed 1024 are out of scope and are caught by an elaboration-time assertion.
- No handshake: the block free-runs and downstream stages sample every cycle.

Optional Feature:
- Macro: VGA_SYNC_ALIGN_EN.
- Defined:
  - hs and vs pass through a 2-stage delay line, so they leave the block 2 clocks after their DrawX/DrawY.
  - The 2 clocks match the renderer path: 1 clock synchronous ROM read plus 1 clock colour output register.
  - Delay-line stages reset to 1.
  - blank, DrawX, DrawY and the strobes are not delayed.
- Undefined: hs and vs are aligned with DrawX/DrawY as above.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL)
  - SYNC_ALIGN_DEPTH = 2
  - typedef coord_t = logic [9:0], shared with the renderers
- One sub-module, vga_delay_line:
  - parameters WIDTH and DEPTH, plus a reset value
  - synchronous active-low reset
  - instantiated only under VGA_SYNC_ALIGN_EN, with WIDTH=2 for {hs,vs}

Test Plan:
- Reset hold: reset_n=0 for 5 clocks -> DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_cnt=0. First edge after release -> DrawX=1.
- Horizontal timing: sample one line -> blank=1 for DrawX 0..639 and 0 at 640. hs=0 exactly for DrawX 656..751 (96 clocks). DrawX 799 -> 0 with DrawY incremented.
- Vertical timing: run a full frame -> vs=0 for all 1600 clocks of lines 490..491. blank=0 throughout lines 480..524. DrawY 524 -> 0 at DrawX 799->0.
- Frame strobes: run 3 frames -> frame_start pulses exactly 420000 clocks apart. line_start pulses every 800 clocks. frame_cnt increments by 1 per frame. Preload run across 256 frames -> 255 wraps to 0.
- Mid-frame reset: assert reset_n=0 at DrawX=700, DrawY=491 (hs=0, vs=0) -> next edge shows hs=1, vs=1, counters 0, and normal timing resumes after release.
- VGA_SYNC_ALIGN_EN build: hs falls 2 clocks after DrawX becomes 656 and rises 2 clocks after DrawX becomes 752. DrawX/blank timing is identical to the non-macro build.
